// File: rtl/imem_arbiter.sv
// imem_arbiter: shares the single-port instruction RAM between the CPU fetch port and a program loader.
// Optional feature: define IMEM_BOOT_EN to hold the CPU in BOOT until the loader pulses ld_done.
module imem_arbiter #(
    parameter int ADDR_W     = 8,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic [31:0]       fetch_addr,
    output logic              fetch_gnt,
    output logic              fetch_valid,
    output logic [31:0]       fetch_instr,
    output logic              cpu_hold,
    input  logic              ld_req,
    input  logic [31:0]       ld_addr,
    input  logic [31:0]       ld_wdata,
    output logic              ld_ack,
    input  logic              ld_done,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int                CNT_W    = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0]  STARVE_C = CNT_W'(STARVE_MAX);
    localparam logic [31:0]       NOP      = 32'h0000_0000;

    logic             in_boot;
    logic             ld_gnt;
    logic             fetch_oor;
    logic             ld_oor;
    logic [CNT_W-1:0] starve_cnt;
    logic             vld_p1;
    logic             ram_p1;
    logic [31:0]      instr_p1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == STARVE_C) ? v : v + CNT_W'(1);
    endfunction

    // Any address bit above the RAM window marks the access as out of range.
    assign fetch_oor = |fetch_addr[31:ADDR_W+2];
    assign ld_oor    = |ld_addr[31:ADDR_W+2];

`ifdef IMEM_BOOT_EN
    typedef enum logic {BOOT, RUN} state_t;

    state_t state;
    state_t state_next;
    logic   unused_addr_lsb;

    assign unused_addr_lsb = ^{fetch_addr[1:0], ld_addr[1:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    // A write presented alongside ld_done is still granted in BOOT.
    always_comb begin
        state_next = state;
        if (state == BOOT && ld_done) begin
            state_next = RUN;
        end
    end

    always_comb begin
        in_boot = (state == BOOT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_hold <= 1'b1;
        end else begin
            cpu_hold <= (state_next == BOOT);
        end
    end
`else
    logic unused_boot_in;

    assign unused_boot_in = ^{fetch_addr[1:0], ld_addr[1:0], ld_done};
    assign in_boot        = 1'b0;
    assign cpu_hold       = 1'b0;
`endif

    // Stage p0: arbitration and RAM request, fetch first unless the loader has waited STARVE_MAX grants.
    always_comb begin
        fetch_gnt = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (!in_boot && fetch_req && !(ld_req && starve_cnt == STARVE_C)) begin
            fetch_gnt = 1'b1;
        end
        ld_gnt = ld_req && !fetch_gnt;
        if (fetch_gnt) begin
            mem_en   = !fetch_oor;
            mem_addr = fetch_addr[ADDR_W+1:2];
        end else if (ld_gnt) begin
            mem_en    = !ld_oor;
            mem_we    = !ld_oor;
            mem_addr  = ld_addr[ADDR_W+1:2];
            mem_wdata = ld_wdata;
        end
    end

    assign ld_ack = ld_gnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (!ld_req || ld_gnt) begin
            starve_cnt <= '0;
        end else if (fetch_gnt) begin
            starve_cnt <= sat_inc(starve_cnt);
        end
    end

    // Stage p1: RAM data returns; out-of-range grants yield a nop, idle cycles hold the last word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p1   <= 1'b0;
            ram_p1   <= 1'b0;
            instr_p1 <= NOP;
        end else begin
            vld_p1   <= fetch_gnt;
            ram_p1   <= fetch_gnt && !fetch_oor;
            instr_p1 <= fetch_instr;
        end
    end

    assign fetch_valid = vld_p1;
    assign fetch_instr = ram_p1 ? mem_rdata : (vld_p1 ? NOP : instr_p1);

endmodule

// File: tb/tb_imem_arbiter.sv
// Testbench for imem_arbiter: directed boot/stream/starvation/range/reset steps plus a randomized phase,
// each cycle checked against a word-array reference model of the arbitration rules.
module tb_imem_arbiter;

    localparam int ADDR_W     = 8;
    localparam int STARVE_MAX = 4;
    localparam int DEPTH      = 1 << ADDR_W;
`ifdef IMEM_BOOT_EN
    localparam bit BOOT_EN = 1'b1;
`else
    localparam bit BOOT_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              fetch_req;
    logic [31:0]       fetch_addr;
    logic              fetch_gnt;
    logic              fetch_valid;
    logic [31:0]       fetch_instr;
    logic              cpu_hold;
    logic              ld_req;
    logic [31:0]       ld_addr;
    logic [31:0]       ld_wdata;
    logic              ld_ack;
    logic              ld_done;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    always #5 clk = ~clk;

    imem_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .reset(reset),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
        .fetch_valid(fetch_valid), .fetch_instr(fetch_instr), .cpu_hold(cpu_hold),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_ack(ld_ack),
        .ld_done(ld_done),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Synchronous single-port RAM attached to the arbiter.
    logic [31:0] ram [DEPTH];
    logic        ram_clear = 1'b1;

    always @(posedge clk) begin
        if (ram_clear) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= 32'h0;
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr];
        end
    end

    // Reference model state
    logic [31:0] ref_mem [DEPTH];
    int          m_cnt;
    bit          m_boot;
    logic [31:0] m_hold;
    int          checks   = 0;
    int          failures = 0;

    function automatic bit oor(input logic [31:0] a);
        return a[31:ADDR_W+2] != '0;
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'(a[ADDR_W+1:2]);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One clock cycle: drive at the falling edge, check grants before the rising edge, results after it.
    task automatic step(input bit freq, input logic [31:0] faddr, input bit lreq,
                        input logic [31:0] laddr, input logic [31:0] lwdata,
                        input bit ldone, output bit acked);
        bit          fg;
        bit          lg;
        logic [31:0] exp_instr;
        fetch_req  = freq;
        fetch_addr = faddr;
        ld_req     = lreq;
        ld_addr    = laddr;
        ld_wdata   = lwdata;
        ld_done    = ldone;
        #1;
        fg = !m_boot && freq && !(lreq && m_cnt == STARVE_MAX);
        lg = lreq && !fg;
        chk("fetch_gnt", fetch_gnt, fg);
        chk("ld_ack", ld_ack, lg);
        chk("mem_en", mem_en, (fg && !oor(faddr)) || (lg && !oor(laddr)));
        chk("mem_we", mem_we, lg && !oor(laddr));
        if (fg && !oor(faddr)) chk("mem_addr_rd", mem_addr, faddr[ADDR_W+1:2]);
        if (lg && !oor(laddr)) begin
            chk("mem_addr_wr", mem_addr, laddr[ADDR_W+1:2]);
            chk("mem_wdata", mem_wdata, lwdata);
        end
        exp_instr = m_hold;
        if (fg) exp_instr = oor(faddr) ? 32'h0 : ref_mem[widx(faddr)];
        if (lg && !oor(laddr)) ref_mem[widx(laddr)] = lwdata;
        if (!lreq || lg) m_cnt = 0;
        else if (fg && m_cnt < STARVE_MAX) m_cnt++;
        if (m_boot && ldone) m_boot = 1'b0;
        @(posedge clk);
        #1;
        chk("fetch_valid", fetch_valid, fg);
        chk("fetch_instr", fetch_instr, exp_instr);
        chk("cpu_hold", cpu_hold, m_boot);
        m_hold = exp_instr;
        acked  = lg;
        @(negedge clk);
    endtask

    task automatic model_reset();
        m_cnt  = 0;
        m_boot = BOOT_EN;
        m_hold = 32'h0;
    endtask

    bit          ack;
    bit          lpend;
    bit          fr;
    bit          lr;
    bit          ldn;
    logic [31:0] fa;
    logic [31:0] la;
    logic [31:0] lw;
    int          wait_cycles;

    initial begin
        reset      = 1'b1;
        fetch_req  = 1'b0;
        fetch_addr = 32'h0;
        ld_req     = 1'b0;
        ld_addr    = 32'h0;
        ld_wdata   = 32'h0;
        ld_done    = 1'b0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
        model_reset();
        #2;
        chk("rst_cpu_hold", cpu_hold, BOOT_EN);
        chk("rst_fetch_valid", fetch_valid, 1'b0);
        chk("rst_fetch_instr", fetch_instr, 32'h0);
        chk("rst_mem_en", mem_en, 1'b0);
        chk("rst_fetch_gnt", fetch_gnt, 1'b0);
        chk("rst_ld_ack", ld_ack, 1'b0);
        @(negedge clk);
        reset     = 1'b0;
        ram_clear = 1'b0;

        // Boot load: word 0 alone, word 1 contending with a fetch, then held with ld_done
        step(0, 32'h0, 1, 32'h0, 32'h2004_0003, 0, ack);
        step(1, 32'h0, 1, 32'h4, 32'h0c10_0005, 0, ack);
        step(0, 32'h0, 1, 32'h4, 32'h0c10_0005, 1, ack);
        step(1, 32'h4, 0, 32'h0, 32'h0, 0, ack);
        chk("boot_word", fetch_instr, 32'h0c10_0005);

        // Streaming fetch, one instruction per cycle
        step(1, 32'h0, 0, 32'h0, 32'h0, 0, ack);
        chk("stream_w0", fetch_instr, 32'h2004_0003);
        step(1, 32'h4, 0, 32'h0, 32'h0, 0, ack);
        step(1, 32'h8, 0, 32'h0, 32'h0, 0, ack);

        // Starvation bound: loader must get through on the (STARVE_MAX+1)th cycle
        wait_cycles = 0;
        ack = 1'b0;
        while (!ack && wait_cycles < 10) begin
            step(1, 32'h0, 1, 32'h10, 32'hcafe_0010, 0, ack);
            wait_cycles++;
        end
        chk("starve_wait", wait_cycles, STARVE_MAX + 1);
        step(1, 32'h10, 1, 32'h14, 32'hcafe_0014, 0, ack);
        chk("starve_cnt_cleared", ack, 1'b0);

        // Out-of-range fetch and loader write
        step(1, 32'h4, 0, 32'h0, 32'h0, 0, ack);
        step(1, 32'h0000_0400, 0, 32'h0, 32'h0, 0, ack);
        chk("oor_nop", fetch_instr, 32'h0);
        step(0, 32'h0, 1, 32'h0000_1000, 32'hdead_beef, 0, ack);
        step(0, 32'h0, 0, 32'h0, 32'h0, 0, ack);

        // Write-then-fetch ordering at word 0xC
        step(1, 32'hc, 1, 32'hc, 32'h1000_ffff, 0, ack);
        chk("wtf_old", fetch_instr, 32'h0);
        step(0, 32'h0, 1, 32'hc, 32'h1000_ffff, 0, ack);
        step(1, 32'hc, 0, 32'h0, 32'h0, 0, ack);
        chk("wtf_new", fetch_instr, 32'h1000_ffff);

        // Randomized traffic with a handshake-respecting loader
        lpend = 1'b0;
        la = 32'h0;
        lw = 32'h0;
        for (int i = 0; i < 400; i++) begin
            fr = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0) fa = 32'h400 + (32'($urandom_range(0, 255)) << 2);
            else                           fa = 32'($urandom_range(0, 31)) << 2;
            if (!lpend) begin
                lr = ($urandom_range(0, 2) == 0);
                if ($urandom_range(0, 15) == 0) la = 32'h1000 + (32'($urandom_range(0, 15)) << 2);
                else                            la = 32'($urandom_range(0, 31)) << 2;
                lw = $urandom;
            end
            ldn = ($urandom_range(0, 19) == 0);
            step(fr, fa, lr, la, lw, ldn, ack);
            lpend = lr && !ack;
        end
        if (lpend) begin
            wait_cycles = 0;
            while (lpend && wait_cycles < 10) begin
                step(0, 32'h0, 1, la, lw, 0, ack);
                lpend = !ack;
                wait_cycles++;
            end
            chk("rand_drain", lpend, 1'b0);
        end

        // Asynchronous reset in the middle of a fetch stream
        step(1, 32'h0, 0, 32'h0, 32'h0, 0, ack);
        chk("pre_reset_valid", fetch_valid, 1'b1);
        fetch_req  = 1'b1;
        fetch_addr = 32'h4;
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_fetch_valid", fetch_valid, 1'b0);
        chk("midrst_cpu_hold", cpu_hold, BOOT_EN);
        chk("midrst_fetch_instr", fetch_instr, 32'h0);
        fetch_req = 1'b0;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        step(1, 32'h4, 0, 32'h0, 32'h0, 0, ack);
        step(0, 32'h0, 0, 32'h0, 32'h0, 1, ack);
        step(1, 32'h0, 0, 32'h0, 32'h0, 0, ack);
        chk("post_reset_word", fetch_instr, ref_mem[0]);
        step(1, 32'h4, 0, 32'h0, 32'h0, 0, ack);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
